adc_capture_ctrl: RTL and testbench

// Sequences the I2S ADC front end: power-up settling, frame lock on lrck,

---
 rtl/adc_capture_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_ctrl
// Purpose  : Sequences the I2S ADC front end. Powers the ADC up and waits
//            for it to settle, locks to lrck, drops the first startup
//            frames, then forwards each stereo pair from the I2S receiver
//            to the DSP chain over a valid/ready handshake. A watchdog on
//            lrck and a full-output detector feed sticky status bits.
// Revision : 1.0 - initial release
//
// Optional : ADC_CAPTURE_FRAME_CNT_EN adds a 16-bit frame_count output
//            that counts accepted handshakes in RUN.
//
// Ports    : clk          system clock
//            rst          synchronous, active-low reset
//            enable       level, 1 = run the ADC, 0 = shut down
//            clr_status   pulse, clears overflow and lock_lost
//            lrck_in      ADC lrck, asynchronous to clk
//            word_strobe  1-clk pulse, lword/rword valid
//            lword/rword  receiver samples
//            adc_pdn      ADC power-down pin (0 = powered down)
//            capture_en   enables receiver shifting
//            m_valid/m_ready/m_lword/m_rword  output handshake
//            state        FSM state (IDLE=0 .. FAULT=5)
//            overflow     sticky, pair dropped while output full
//            lock_lost    sticky, lrck watchdog expired
//            frame_count  accepted pairs (ADC_CAPTURE_FRAME_CNT_EN only)
// ============================================================================
module adc_capture_ctrl #(
    parameter int DATA_W         = 24,
    parameter int SETTLE_CLKS    = 1024,
    parameter int DISCARD_FRAMES = 4,
    parameter int WDOG_CLKS      = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clr_status,
    input  logic              lrck_in,
    input  logic              word_strobe,
    input  logic [DATA_W-1:0] lword,
    input  logic [DATA_W-1:0] rword,
    output logic              adc_pdn,
    output logic              capture_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_lword,
    output logic [DATA_W-1:0] m_rword,
    output logic [2:0]        state,
    output logic              overflow,
`ifdef ADC_CAPTURE_FRAME_CNT_EN
    output logic [15:0]       frame_count,
`endif
    output logic              lock_lost
);

    localparam int SETTLE_W = $clog2(SETTLE_CLKS) + 1;
    localparam int DISC_W   = $clog2(DISCARD_FRAMES) + 1;
    localparam int WDOG_W   = $clog2(WDOG_CLKS) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POWERUP = 3'd1,
        S_SYNC    = 3'd2,
        S_DISCARD = 3'd3,
        S_RUN     = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [DISC_W-1:0]   disc_q, disc_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                lrck_s1_q, lrck_s2_q, lrck_s3_q;
    logic                lrck_rise;
    logic                lock_set;
    logic                ovf_set;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_lword_q, m_lword_d;
    logic [DATA_W-1:0]   m_rword_q, m_rword_d;
    logic                overflow_q, overflow_d;
    logic                lock_lost_q, lock_lost_d;

    // lrck is asynchronous: two flops to resolve metastability, a third
    // to detect the rising edge in the clk domain.
    assign lrck_rise = lrck_s2_q & ~lrck_s3_q;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            disc_q    <= '0;
            wdog_q    <= '0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            lrck_s3_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            disc_q    <= disc_d;
            wdog_q    <= wdog_d;
            lrck_s1_q <= lrck_in;
            lrck_s2_q <= lrck_s1_q;
            lrck_s3_q <= lrck_s2_q;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        disc_d   = '0;
        wdog_d   = '0;
        lock_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_POWERUP;
            end
            S_POWERUP: begin
                if (settle_q == SETTLE_W'(SETTLE_CLKS - 1)) begin
                    state_d = S_SYNC;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SYNC: begin
                if (lrck_rise) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                disc_d = disc_q;
                if (word_strobe) begin
                    if (disc_q == DISC_W'(DISCARD_FRAMES - 1)) begin
                        state_d = S_RUN;
                        disc_d  = '0;
                    end else begin
                        disc_d = disc_q + 1'b1;
                    end
                end
            end
            S_RUN:   ;
            S_FAULT: ;
            default: state_d = S_IDLE;
        endcase

        // Watchdog covers every state that depends on a live lrck; its
        // expiry overrides any normal transition taken this cycle.
        if (state_q == S_SYNC || state_q == S_DISCARD || state_q == S_RUN) begin
            if (lrck_rise) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_W'(WDOG_CLKS - 1)) begin
                state_d  = S_FAULT;
                lock_set = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end

        if (!enable) begin
            state_d  = S_IDLE;
            settle_d = '0;
            disc_d   = '0;
            wdog_d   = '0;
            lock_set = 1'b0;
        end
    end

    // ---------------- Output datapath and status ----------------
    always_comb begin
        m_valid_d = m_valid_q;
        m_lword_d = m_lword_q;
        m_rword_d = m_rword_q;
        ovf_set   = 1'b0;

        if (state_q == S_RUN) begin
            if (word_strobe) begin
                // A strobe coinciding with acceptance refills the slot
                // directly, so valid never drops and nothing is lost.
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b1;
                    m_lword_d = lword;
                    m_rword_d = rword;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
            end
        end

        // Leaving RUN for any reason discards the pending pair.
        if (state_d != S_RUN) m_valid_d = 1'b0;

        overflow_d  = ovf_set  | (overflow_q  & ~clr_status);
        lock_lost_d = lock_set | (lock_lost_q & ~clr_status);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q   <= 1'b0;
            m_lword_q   <= '0;
            m_rword_q   <= '0;
            overflow_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_lword_q   <= m_lword_d;
            m_rword_q   <= m_rword_d;
            overflow_q  <= overflow_d;
            lock_lost_q <= lock_lost_d;
        end
    end

`ifdef ADC_CAPTURE_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == S_RUN && m_valid_q && m_ready) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (state_d == S_IDLE) frame_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) frame_cnt_q <= '0;
        else      frame_cnt_q <= frame_cnt_d;
    end

    assign frame_count = frame_cnt_q;
`endif

    assign adc_pdn    = (state_q != S_IDLE);
    assign capture_en = (state_q == S_DISCARD) || (state_q == S_RUN);
    assign m_valid    = m_valid_q;
    assign m_lword    = m_lword_q;
    assign m_rword    = m_rword_q;
    assign state      = state_q;
    assign overflow   = overflow_q;
    assign lock_lost  = lock_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_ctrl
// Purpose  : Directed self-checking bench for adc_capture_ctrl with
//            SETTLE_CLKS=8, DISCARD_FRAMES=2, WDOG_CLKS=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clr_status = 1'b0;
    logic        lrck_in = 1'b0;
    logic        word_strobe = 1'b0;
    logic [23:0] lword = '0;
    logic [23:0] rword = '0;
    logic        m_ready = 1'b0;
    logic        adc_pdn, capture_en, m_valid, overflow, lock_lost;
    logic [23:0] m_lword, m_rword;
    logic [2:0]  state;
`ifdef ADC_CAPTURE_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    int total = 0;
    int bad   = 0;
    logic lrck_run = 1'b0;

    adc_capture_ctrl #(
        .DATA_W(24), .SETTLE_CLKS(8), .DISCARD_FRAMES(2), .WDOG_CLKS(32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
        .lrck_in(lrck_in), .word_strobe(word_strobe), .lword(lword),
        .rword(rword), .adc_pdn(adc_pdn), .capture_en(capture_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_lword(m_lword),
        .m_rword(m_rword), .state(state), .overflow(overflow),
`ifdef ADC_CAPTURE_FRAME_CNT_EN
        .frame_count(frame_count),
`endif
        .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // lrck: toggles every 8 clks (rise every 16) while lrck_run is set.
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            if (lrck_run) begin
                ph++;
                if (ph == 8) begin
                    lrck_in = ~lrck_in;
                    ph = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        lword = l;
        rword = r;
        word_strobe = 1'b1;
        tick();
        word_strobe = 1'b0;
    endtask

    task automatic wait_capture();
        for (int i = 0; i < 40 && capture_en !== 1'b1; i++) tick();
        total++; if (capture_en !== 1'b1) begin bad++; $display("FAIL lock_wait: capture_en=%b want 1", capture_en); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if ({adc_pdn, capture_en, m_valid, overflow, lock_lost} !== 5'b0) begin bad++; $display("FAIL reset_outs: got %b want 00000", {adc_pdn, capture_en, m_valid, overflow, lock_lost}); end
        total++; if (m_lword !== 24'h0) begin bad++; $display("FAIL reset_lword: got %h want 000000", m_lword); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_startup();
        enable = 1'b1;
        tick();
        total++; if (adc_pdn !== 1'b1 || state !== 3'd1) begin bad++; $display("FAIL powerup_entry: pdn=%b state=%0d want 1/1", adc_pdn, state); end
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (state !== 3'd1) begin bad++; $display("FAIL settle_hold: cycle %0d state=%0d want 1", i, state); end
        end
        tick();
        total++; if (state !== 3'd2 || capture_en !== 1'b0) begin bad++; $display("FAIL sync_entry: state=%0d cap=%b want 2/0", state, capture_en); end
        lrck_run = 1'b1;
        wait_capture();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL discard_entry: state=%0d want 3", state); end
        strobe(24'h111111, 24'h222222);
        total++; if (m_valid !== 1'b0 || state !== 3'd3) begin bad++; $display("FAIL discard_1: valid=%b state=%0d want 0/3", m_valid, state); end
        strobe(24'h333333, 24'h444444);
        total++; if (m_valid !== 1'b0 || state !== 3'd4) begin bad++; $display("FAIL discard_2: valid=%b state=%0d want 0/4", m_valid, state); end
        strobe(24'h123456, 24'h654321);
        total++; if (m_valid !== 1'b1 || m_lword !== 24'h123456 || m_rword !== 24'h654321) begin bad++; $display("FAIL first_pair: valid=%b l=%h r=%h want 1/123456/654321", m_valid, m_lword, m_rword); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b1;
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL accept_clear: valid=%b want 0", m_valid); end
        m_ready = 1'b0;
        strobe(24'hAAAAAA, 24'hA0A0A0);
        total++; if (m_valid !== 1'b1 || m_lword !== 24'hAAAAAA || overflow !== 1'b0) begin bad++; $display("FAIL bp_load: valid=%b l=%h ovf=%b want 1/aaaaaa/0", m_valid, m_lword, overflow); end
        strobe(24'h555555, 24'h505050);
        total++; if (m_lword !== 24'hAAAAAA || m_rword !== 24'hA0A0A0 || overflow !== 1'b1) begin bad++; $display("FAIL bp_drop: l=%h r=%h ovf=%b want aaaaaa/a0a0a0/1", m_lword, m_rword, overflow); end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: ovf=%b want 0", overflow); end
        clr_status = 1'b1;
        strobe(24'h777777, 24'h070707);
        clr_status = 1'b0;
        total++; if (overflow !== 1'b1 || m_lword !== 24'hAAAAAA) begin bad++; $display("FAIL set_wins: ovf=%b l=%h want 1/aaaaaa", overflow, m_lword); end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    task automatic test_simultaneous();
        m_ready = 1'b1;
        strobe(24'hBBBBBB, 24'hCCCCCC);
        total++; if (m_valid !== 1'b1 || m_lword !== 24'hBBBBBB || m_rword !== 24'hCCCCCC || overflow !== 1'b0) begin bad++; $display("FAIL simul: valid=%b l=%h r=%h ovf=%b want 1/bbbbbb/cccccc/0", m_valid, m_lword, m_rword, overflow); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL simul_drain: valid=%b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

`ifdef ADC_CAPTURE_FRAME_CNT_EN
    task automatic test_frame_count();
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL fc_three: got %0d want 3", frame_count); end
        m_ready = 1'b1;
        word_strobe = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            lword = 24'(i);
            tick();
        end
        word_strobe = 1'b0;
        tick();
        total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL fc_full: got %h want ffff", frame_count); end
        strobe(24'h010203, 24'h040506);
        tick();
        total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL fc_wrap: got %h want 0000", frame_count); end
        m_ready = 1'b0;
    endtask
`endif

    task automatic test_watchdog();
        int cyc;
        strobe(24'hDEAD01, 24'hBEEF01);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL wd_pending: valid=%b want 1", m_valid); end
        lrck_run = 1'b0;
        cyc = 0;
        while (cyc < 40 && state !== 3'd5) begin
            tick();
            cyc++;
        end
        total++; if (state !== 3'd5 || cyc > 35) begin bad++; $display("FAIL wd_fault: state=%0d after %0d clks want 5 within 35", state, cyc); end
        total++; if (lock_lost !== 1'b1 || m_valid !== 1'b0 || capture_en !== 1'b0 || adc_pdn !== 1'b1) begin bad++; $display("FAIL wd_outs: lost=%b valid=%b cap=%b pdn=%b want 1/0/0/1", lock_lost, m_valid, capture_en, adc_pdn); end
        repeat (5) tick();
        total++; if (state !== 3'd5) begin bad++; $display("FAIL fault_hold: state=%0d want 5", state); end
    endtask

    task automatic test_abort();
        enable = 1'b0;
        tick();
        total++; if (state !== 3'd0 || adc_pdn !== 1'b0) begin bad++; $display("FAIL fault_exit: state=%0d pdn=%b want 0/0", state, adc_pdn); end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL lost_clear: lost=%b want 0", lock_lost); end
        enable = 1'b1;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        total++; if (state !== 3'd0 || adc_pdn !== 1'b0) begin bad++; $display("FAIL abort_powerup: state=%0d pdn=%b want 0/0", state, adc_pdn); end
        enable = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (state !== 3'd1) begin bad++; $display("FAIL resettle: cycle %0d state=%0d want 1", i, state); end
        end
        tick();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL resettle_done: state=%0d want 2", state); end
        lrck_run = 1'b1;
        wait_capture();
        strobe(24'h000001, 24'h000002);
        strobe(24'h000003, 24'h000004);
        strobe(24'h0ABCDE, 24'h0EDCBA);
        total++; if (state !== 3'd4 || m_valid !== 1'b1 || m_lword !== 24'h0ABCDE) begin bad++; $display("FAIL rerun: state=%0d valid=%b l=%h want 4/1/0abcde", state, m_valid, m_lword); end
        enable = 1'b0;
        tick();
        total++; if (state !== 3'd0 || m_valid !== 1'b0 || adc_pdn !== 1'b0 || capture_en !== 1'b0) begin bad++; $display("FAIL abort_run: state=%0d valid=%b pdn=%b cap=%b want 0/0/0/0", state, m_valid, adc_pdn, capture_en); end
`ifdef ADC_CAPTURE_FRAME_CNT_EN
        total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL fc_idle_clear: got %h want 0000", frame_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_simultaneous();
`ifdef ADC_CAPTURE_FRAME_CNT_EN
        test_frame_count();
`endif
        test_watchdog();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
